loop_seq: RTL
=============

LOOP_SEQ -- requirements
Module: loop_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning maximum nesting depth (2..8).
REQ-002 SHALL have parameter ADDR_W, default 6, meaning instruction address width.
REQ-003 SHALL have parameter CNT_W, default 12, meaning iteration count width.
REQ-004 SHALL have parameter LVAL_W, default 5, meaning loop-value CRF index width.
REQ-005 SHALL have port Clk, input, 1 bit: clock, rising edge.
REQ-006 SHALL have port Reset, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port en, input, 1 bit: advance enable (clock-gate enable AND NOT global stall).
REQ-008 SHALL have port pc_i, input, ADDR_W bits: address of the current instruction.
REQ-009 SHALL have ports init_v / cnt_v, input, 1 bit each: current instruction is LOOP_INIT / LOOP_CNT.
REQ-010 SHALL have ports ls_i and le_i, input, ADDR_W bits each: loop start and loop end fields (LOOP_INIT).
REQ-011 SHALL have port lvalf_i, input, 1 bit: loop-value update flag (LOOP_INIT).
REQ-012 SHALL have ports lc_i, input, CNT_W bits, and lidx_i, input, LVAL_W bits: iteration count and CRF index (LOOP_CNT).
REQ-013 SHALL have port next_pc_o, output, ADDR_W bits: next fetch address, combinational.
REQ-014 SHALL have port depth_o, output, $clog2(DEPTH+1) bits: number of active loops.
REQ-015 SHALL have ports lval_req_o, output, 1 bit, and lval_idx_o, output, LVAL_W bits: CRF loop-value update pulse and its index.
REQ-016 SHALL have port lval_init_o, output, 1 bit: asserted with lval_req_o when the loop value is to be initialised rather than stepped.
REQ-017 SHALL have port exit_o, output, $clog2(DEPTH+1) bits: number of loops popped in the previous cycle.

Function
REQ-018 SHALL hold a stack of DEPTH entries {ls, le, lc[CNT_W], lvalf, lidx} and a stack pointer sp (= depth_o).
REQ-019 SHALL, on en & init_v, write ls, le and lvalf into entry[sp] without changing sp.
REQ-020 SHALL, on en & cnt_v, write lc = lc_i-1 (lc_i = 0 treated as 1, i.e. lc = 0) and lidx = lidx_i into entry[sp], then increment sp.
REQ-021 SHALL, on a LOOP_CNT push with lvalf set, pulse lval_req_o and lval_init_o for one cycle, with lval_idx_o = lidx_i.
REQ-022 SHALL evaluate the end-match cascade from the top entry downward, when neither init_v nor cnt_v is set:
- pc_i == le and lc > 0: the match branches (next_pc_o = ls), and lc is decremented on en.
- pc_i == le and lc == 0: the entry is popped and evaluation continues with the next entry down.
- pc_i != le, or the stack is empty: evaluation stops.
REQ-023 SHALL drive next_pc_o = pc_i+1 (modulo 2^ADDR_W) when no branch occurs.
REQ-024 SHALL, when an entry branches with lvalf set, pulse lval_req_o next cycle with lval_idx_o = that entry's lidx and lval_init_o = 1 if at least one inner loop popped in the same cycle, else 0.
REQ-025 SHALL register exit_o = pop count; 0 when idle.
REQ-026 SHALL give init_v/cnt_v priority over end-match; no decrement or pop occurs in that cycle.
REQ-027 SHALL, when en = 0, leave all state unchanged and force lval_req_o, lval_init_o and exit_o to 0 in the next cycle; next_pc_o remains combinationally valid.
REQ-028 SHALL ignore cnt_v when sp == DEPTH (no write, sp unchanged).
REQ-029 SHALL, when the whole stack pops, continue from pc_i+1 with sp = 0.

Reset
REQ-030 SHALL, with Reset low, asynchronously clear sp, every entry, lval_req_o, lval_init_o, lval_idx_o and exit_o to 0.
REQ-031 SHALL, on reset asserted mid-loop, discard all loops; the first cycle after release behaves as an empty stack (next_pc_o = pc_i+1).

Configuration
REQ-032 SHALL, with LOOP_SEQ_ERR_EN defined, add output err_o (1 bit, sticky) that is set on push at sp == DEPTH and on LOOP_INIT at sp == DEPTH, and is cleared only by Reset.
REQ-033 SHALL, without LOOP_SEQ_ERR_EN, have no err_o port, with overflow silently ignored per REQ-028.

Structure
REQ-034 SHALL define the loop-entry struct typedef and the default parameter constants in shared package loop_pkg.
REQ-035 SHALL implement the combinational end-match cascade in sub-module loop_match (inputs: stack and pc_i; outputs: branch, target, branch index, pop count).

Verification
REQ-036 SHALL verify single loop: INIT ls=2, le=5; CNT lc_i=3 -> PC sequence 2..5 three times, then 6; depth_o goes 1->0; exit_o=1 once.
REQ-037 SHALL verify nested loops sharing end address: outer ls=1, le=8, lc_i=2; inner ls=4, le=8, lc_i=2 -> at the inner-exit PC 8, next_pc_o=1, exit_o=1, outer lc decremented; total inner body executions = 4.
REQ-038 SHALL verify lvalf: lvalf=1, lidx_i=9 -> lval_req_o with lval_init_o=1 on CNT, then lval_req_o with lval_init_o=0 and lval_idx_o=9 at each branch back.
REQ-039 SHALL verify stall: en=0 for 3 cycles at PC=le -> lc and sp unchanged, no pulses; release -> normal branch.
REQ-040 SHALL verify overflow: DEPTH+1 pushes -> sp == DEPTH, err_o=1 (macro on); the extra push is ignored.
REQ-041 SHALL verify reset mid-loop: Reset low at the 2nd iteration -> sp=0 and all outputs 0; after release next_pc_o = pc_i+1.

Source files
------------

// File: rtl/loop_pkg.sv
// rtl/loop_pkg.sv - shared loop-stack entry type and default parameter constants
package loop_pkg;

  // Default instance configuration; the entry fields below are sized by these,
  // so instance widths must not exceed them.
  localparam int LOOP_DEPTH  = 4;
  localparam int LOOP_ADDR_W = 6;
  localparam int LOOP_CNT_W  = 12;
  localparam int LOOP_LVAL_W = 5;

  // One hardware loop: body bounds, remaining branch-backs, loop-value tracking
  typedef struct packed {
    logic [LOOP_ADDR_W-1:0] ls;
    logic [LOOP_ADDR_W-1:0] le;
    logic [LOOP_CNT_W-1:0]  lc;
    logic                   lvalf;
    logic [LOOP_LVAL_W-1:0] lidx;
  } loop_entry_t;

  // Iterations requested by LOOP_CNT map to remaining branch-backs; 0 behaves as 1
  function automatic logic [LOOP_CNT_W-1:0] loop_cnt_load(input logic [LOOP_CNT_W-1:0] lc);
    loop_cnt_load = (lc == '0) ? '0 : lc - LOOP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/loop_match.sv
// rtl/loop_match.sv - combinational end-address match cascade over the loop stack
module loop_match
  import loop_pkg::*;
#(
  parameter int DEPTH  = LOOP_DEPTH,
  parameter int ADDR_W = LOOP_ADDR_W,
  parameter int SP_W   = $clog2(DEPTH+1),
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  loop_entry_t [DEPTH-1:0] stack,
  input  logic [SP_W-1:0]         sp,
  input  logic [ADDR_W-1:0]       pc_i,
  output logic                    branch,
  output logic [ADDR_W-1:0]       target,
  output logic [IDX_W-1:0]        branch_idx,
  output logic                    branch_lvalf,
  output logic [LOOP_LVAL_W-1:0]  branch_lidx,
  output logic [SP_W-1:0]         pop_cnt
);

  logic scan;

  // Walk from the innermost active loop outward: finished loops ending here pop,
  // the first unfinished one branches, any non-matching end address stops the walk
  always_comb begin
    branch       = 1'b0;
    target       = pc_i + ADDR_W'(1);
    branch_idx   = '0;
    branch_lvalf = 1'b0;
    branch_lidx  = '0;
    pop_cnt      = '0;
    scan         = 1'b1;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (scan && (i < int'(sp))) begin
        if (pc_i == stack[i].le[ADDR_W-1:0]) begin
          if (stack[i].lc != '0) begin
            branch       = 1'b1;
            target       = stack[i].ls[ADDR_W-1:0];
            branch_idx   = IDX_W'(i);
            branch_lvalf = stack[i].lvalf;
            branch_lidx  = stack[i].lidx;
            scan         = 1'b0;
          end else begin
            pop_cnt = pop_cnt + SP_W'(1);
          end
        end else begin
          scan = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/loop_seq.sv
// rtl/loop_seq.sv - zero-overhead nested hardware loop sequencer; LOOP_SEQ_ERR_EN adds sticky overflow flag err_o
module loop_seq
  import loop_pkg::*;
#(
  parameter int DEPTH  = LOOP_DEPTH,
  parameter int ADDR_W = LOOP_ADDR_W,
  parameter int CNT_W  = LOOP_CNT_W,
  parameter int LVAL_W = LOOP_LVAL_W
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       en,
  input  logic [ADDR_W-1:0]          pc_i,
  input  logic                       init_v,
  input  logic                       cnt_v,
  input  logic [ADDR_W-1:0]          ls_i,
  input  logic [ADDR_W-1:0]          le_i,
  input  logic                       lvalf_i,
  input  logic [CNT_W-1:0]           lc_i,
  input  logic [LVAL_W-1:0]          lidx_i,
  output logic [ADDR_W-1:0]          next_pc_o,
  output logic [$clog2(DEPTH+1)-1:0] depth_o,
  output logic                       lval_req_o,
  output logic [LVAL_W-1:0]          lval_idx_o,
  output logic                       lval_init_o,
  output logic [$clog2(DEPTH+1)-1:0] exit_o
`ifdef LOOP_SEQ_ERR_EN
  ,
  output logic                       err_o
`endif
);

  localparam int SP_W  = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);

  loop_entry_t [DEPTH-1:0] stack;
  logic [SP_W-1:0]         sp;
  logic                    full;
  logic [IDX_W-1:0]        top_idx;
  logic                    instr_v;

  logic                    m_branch;
  logic [ADDR_W-1:0]       m_target;
  logic [IDX_W-1:0]        m_idx;
  logic                    m_lvalf;
  logic [LOOP_LVAL_W-1:0]  m_lidx;
  logic [SP_W-1:0]         m_pop;

  assign full    = (sp == SP_W'(DEPTH));
  assign top_idx = sp[IDX_W-1:0];
  assign instr_v = init_v | cnt_v;
  assign depth_o = sp;

  loop_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .SP_W   (SP_W),
    .IDX_W  (IDX_W)
  ) u_match (
    .stack        (stack),
    .sp           (sp),
    .pc_i         (pc_i),
    .branch       (m_branch),
    .target       (m_target),
    .branch_idx   (m_idx),
    .branch_lvalf (m_lvalf),
    .branch_lidx  (m_lidx),
    .pop_cnt      (m_pop)
  );

  // Loop instructions never branch; otherwise take the cascade's target (pc+1 if none)
  always_comb begin
    next_pc_o = pc_i + ADDR_W'(1);
    if (!instr_v && m_branch) begin
      next_pc_o = m_target;
    end
  end

  // Stack, stack pointer and one-cycle loop-value / exit reporting
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stack       <= '0;
      sp          <= '0;
      lval_req_o  <= 1'b0;
      lval_init_o <= 1'b0;
      lval_idx_o  <= '0;
      exit_o      <= '0;
    end else begin
      lval_req_o  <= 1'b0;
      lval_init_o <= 1'b0;
      exit_o      <= '0;
      if (en) begin
        if (init_v) begin
          // LOOP_INIT stages bounds into the free slot; the push happens at LOOP_CNT
          if (!full) begin
            stack[top_idx].ls    <= LOOP_ADDR_W'(ls_i);
            stack[top_idx].le    <= LOOP_ADDR_W'(le_i);
            stack[top_idx].lvalf <= lvalf_i;
          end
        end else if (cnt_v) begin
          if (!full) begin
            stack[top_idx].lc   <= loop_cnt_load(LOOP_CNT_W'(lc_i));
            stack[top_idx].lidx <= LOOP_LVAL_W'(lidx_i);
            sp                  <= sp + SP_W'(1);
            if (stack[top_idx].lvalf) begin
              lval_req_o  <= 1'b1;
              lval_init_o <= 1'b1;
              lval_idx_o  <= lidx_i;
            end
          end
        end else begin
          if (m_branch) begin
            stack[m_idx].lc <= stack[m_idx].lc - LOOP_CNT_W'(1);
            // A fresh inner-loop pass starts when an inner loop finished on this branch
            if (m_lvalf) begin
              lval_req_o  <= 1'b1;
              lval_init_o <= (m_pop != '0);
              lval_idx_o  <= LVAL_W'(m_lidx);
            end
          end
          sp     <= sp - m_pop;
          exit_o <= m_pop;
        end
      end
    end
  end

`ifdef LOOP_SEQ_ERR_EN
  // Sticky overflow: any LOOP_INIT or LOOP_CNT arriving with the stack full
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      err_o <= 1'b0;
    end else if (en && instr_v && full) begin
      err_o <= 1'b1;
    end
  end
`endif

endmodule
